// File: rtl/lc3_mem_arbiter_pkg.sv
// Shared types and constants for the LC-3 memory arbiter:
// the sequencer state encoding, requester port IDs and default widths.
package lc3_mem_pkg;

  localparam int LC3_DATA_WIDTH = 16;
  localparam int LC3_ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DMA = 1'b1
  } port_id_t;

endpackage

// File: rtl/lc3_mem_arbiter_if.sv
// One requester-side memory port: the requester drives req/we/addr/wdata,
// the arbiter answers with a one-cycle ack plus rdata/err.
interface lc3_mem_arbiter_if
  import lc3_mem_pkg::*;
#(
  parameter int DATA_WIDTH = LC3_DATA_WIDTH,
  parameter int ADDR_WIDTH = LC3_ADDR_WIDTH
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ack;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;

  modport master (output req, we, addr, wdata, input ack, rdata, err);
  modport slave  (input req, we, addr, wdata, output ack, rdata, err);
endinterface

// File: rtl/lc3_mem_arbiter_rr.sv
// Combinational two-port grant logic: a lone requester always wins; on a tie
// either cpu wins (fixed priority) or the port that did not own the RAM last.
module lc3_rr_arbiter2
  import lc3_mem_pkg::*;
#(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic [1:0] i_req,
  input  port_id_t   i_last_owner,
  output port_id_t   o_grant
);

  // Grant decode; the no-request case is don't-care for the caller.
  always_comb begin
    o_grant = PORT_CPU;
    case (i_req)
      2'b01:   o_grant = PORT_CPU;
      2'b10:   o_grant = PORT_DMA;
      2'b11: begin
        if (FIXED_PRIORITY != 0) begin
          o_grant = PORT_CPU;
        end else if (i_last_owner == PORT_CPU) begin
          o_grant = PORT_DMA;
        end else begin
          o_grant = PORT_CPU;
        end
      end
      default: o_grant = PORT_CPU;
    endcase
  end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Two-port arbiter/sequencer in front of lc3_ram: IDLE -> ISSUE -> WAIT -> RESP,
// with a bounded wait for RAM ready and a registered one-cycle ack per access.
module lc3_mem_arbiter
  import lc3_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = LC3_DATA_WIDTH,
  parameter int ADDR_WIDTH     = LC3_ADDR_WIDTH,
  parameter int FIXED_PRIORITY = 0,
  parameter int WAIT_LIMIT     = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  lc3_mem_arbiter_if.slave      cpu,
  lc3_mem_arbiter_if.slave      dma,
  output logic                  ram_cs,
  output logic                  ram_r_w,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic                  ram_ready,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  busy
);

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  arb_state_t            r_state;
  port_id_t              r_owner;
  port_id_t              r_last_owner;
  logic                  r_we;
  logic [7:0]            r_wait_cnt;
  logic                  r_ram_cs;
  logic                  r_ram_r_w;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_data_in;
  logic                  r_busy;
  logic                  r_cpu_ack, r_cpu_err, r_dma_ack, r_dma_err;
  logic [DATA_WIDTH-1:0] r_cpu_rdata, r_dma_rdata;

  arb_state_t            w_state_nxt;
  port_id_t              w_grant;
  logic [1:0]            w_req;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic [DATA_WIDTH-1:0] w_resp_rdata;
  logic                  w_resp_err;
  logic                  w_to_resp;

  assign w_req = {dma.req, cpu.req};

  lc3_rr_arbiter2 #(.FIXED_PRIORITY(FIXED_PRIORITY)) u_rr (
    .i_req        (w_req),
    .i_last_owner (r_last_owner),
    .o_grant      (w_grant)
  );

  assign w_sel_we    = (w_grant == PORT_DMA) ? dma.we    : cpu.we;
  assign w_sel_addr  = (w_grant == PORT_DMA) ? dma.addr  : cpu.addr;
  assign w_sel_wdata = (w_grant == PORT_DMA) ? dma.wdata : cpu.wdata;
  assign w_to_resp   = (r_state == WAIT) && (w_state_nxt == RESP);

  // Next-state and response payload; a write completion returns zero data.
  always_comb begin
    w_state_nxt  = r_state;
    w_resp_rdata = '0;
    w_resp_err   = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_req) w_state_nxt = ISSUE;
        else        w_state_nxt = IDLE;
      end
      ISSUE: w_state_nxt = WAIT;
      WAIT: begin
        if (ram_ready) begin
          w_state_nxt  = RESP;
          w_resp_rdata = r_we ? '0 : ram_data_out;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_state_nxt = RESP;
          w_resp_err  = 1'b1;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register, request latches and every registered output.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_owner       <= PORT_CPU;
      r_last_owner  <= PORT_DMA;
      r_we          <= 1'b0;
      r_wait_cnt    <= 8'd0;
      r_ram_cs      <= 1'b0;
      r_ram_r_w     <= 1'b0;
      r_ram_addr    <= '0;
      r_ram_data_in <= '0;
      r_busy        <= 1'b0;
      r_cpu_ack     <= 1'b0;
      r_cpu_err     <= 1'b0;
      r_cpu_rdata   <= '0;
      r_dma_ack     <= 1'b0;
      r_dma_err     <= 1'b0;
      r_dma_rdata   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      if ((r_state == IDLE) && (|w_req)) begin
        r_owner       <= w_grant;
        r_last_owner  <= w_grant;
        r_we          <= w_sel_we;
        r_ram_addr    <= w_sel_addr;
        r_ram_data_in <= w_sel_wdata;
      end
      // Strobes are only asserted for the single ISSUE cycle.
      r_ram_cs   <= (r_state == IDLE) && (|w_req);
      r_ram_r_w  <= (r_state == IDLE) && (|w_req) && w_sel_we;
      r_wait_cnt <= (r_state == WAIT) ? (r_wait_cnt + 8'd1) : 8'd0;

      r_cpu_ack   <= w_to_resp && (r_owner == PORT_CPU);
      r_cpu_err   <= w_to_resp && (r_owner == PORT_CPU) && w_resp_err;
      r_cpu_rdata <= (w_to_resp && (r_owner == PORT_CPU)) ? w_resp_rdata : '0;
      r_dma_ack   <= w_to_resp && (r_owner == PORT_DMA);
      r_dma_err   <= w_to_resp && (r_owner == PORT_DMA) && w_resp_err;
      r_dma_rdata <= (w_to_resp && (r_owner == PORT_DMA)) ? w_resp_rdata : '0;
    end
  end

  assign ram_cs      = r_ram_cs;
  assign ram_r_w     = r_ram_r_w;
  assign ram_addr    = r_ram_addr;
  assign ram_data_in = r_ram_data_in;
  assign busy        = r_busy;
  assign cpu.ack     = r_cpu_ack;
  assign cpu.err     = r_cpu_err;
  assign cpu.rdata   = r_cpu_rdata;
  assign dma.ack     = r_dma_ack;
  assign dma.err     = r_dma_err;
  assign dma.rdata   = r_dma_rdata;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed bench: round-robin instance with a RAM model that can stall ready,
// plus a fixed-priority instance used for the tie-break ordering check.
module tb_lc3_mem_arbiter;
  import lc3_mem_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  lc3_mem_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) cpu0 ();
  lc3_mem_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) dma0 ();
  lc3_mem_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) cpu1 ();
  lc3_mem_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) dma1 ();

  logic        ram0_cs, ram0_rw, ram0_ready, busy0;
  logic [15:0] ram0_addr, ram0_din, ram0_dout;
  logic        ram1_cs, ram1_rw, ram1_ready, busy1;
  logic [15:0] ram1_addr, ram1_din, ram1_dout;
  logic        ram0_rdy_r = 1'b0;
  logic        ram1_rdy_r = 1'b0;
  logic        stall = 1'b0;
  logic [15:0] mem [0:65535];

  int n_assert = 0;
  int n_fail   = 0;

  lc3_mem_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .FIXED_PRIORITY(0), .WAIT_LIMIT(15)) dut0 (
    .clk(clk), .reset_n(reset_n), .cpu(cpu0), .dma(dma0),
    .ram_cs(ram0_cs), .ram_r_w(ram0_rw), .ram_addr(ram0_addr), .ram_data_in(ram0_din),
    .ram_ready(ram0_ready), .ram_data_out(ram0_dout), .busy(busy0)
  );

  lc3_mem_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .FIXED_PRIORITY(1), .WAIT_LIMIT(15)) dut1 (
    .clk(clk), .reset_n(reset_n), .cpu(cpu1), .dma(dma1),
    .ram_cs(ram1_cs), .ram_r_w(ram1_rw), .ram_addr(ram1_addr), .ram_data_in(ram1_din),
    .ram_ready(ram1_ready), .ram_data_out(ram1_dout), .busy(busy1)
  );

  // RAM model: ready the cycle after cs, write commits at the cs edge.
  assign ram0_ready = ram0_rdy_r & ~stall;
  always @(posedge clk) begin
    ram0_rdy_r <= ram0_cs;
    ram0_dout  <= mem[ram0_addr];
    if (ram0_cs && ram0_rw) mem[ram0_addr] <= ram0_din;
  end

  // Second RAM returns the read address as data.
  assign ram1_ready = ram1_rdy_r;
  always @(posedge clk) begin
    ram1_rdy_r <= ram1_cs;
    ram1_dout  <= ram1_addr | (ram1_din & {16{ram1_rw}});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset0(input string pfx);
    check({pfx, "_busy"},      32'(busy0),       32'd0);
    check({pfx, "_ram_cs"},    32'(ram0_cs),     32'd0);
    check({pfx, "_ram_r_w"},   32'(ram0_rw),     32'd0);
    check({pfx, "_ram_addr"},  32'(ram0_addr),   32'd0);
    check({pfx, "_ram_din"},   32'(ram0_din),    32'd0);
    check({pfx, "_cpu_ack"},   32'(cpu0.ack),    32'd0);
    check({pfx, "_cpu_rdata"}, 32'(cpu0.rdata),  32'd0);
    check({pfx, "_cpu_err"},   32'(cpu0.err),    32'd0);
    check({pfx, "_dma_ack"},   32'(dma0.ack),    32'd0);
    check({pfx, "_dma_rdata"}, 32'(dma0.rdata),  32'd0);
    check({pfx, "_dma_err"},   32'(dma0.err),    32'd0);
  endtask

  // One access on dut0; cycles counts negedges from the req-sampling edge to ack (-1 if none).
  task automatic access0(input bit port, input bit we, input logic [15:0] addr, input logic [15:0] wdata,
                         input int budget, output logic [15:0] rdata, output logic err,
                         output int cycles, output int cs_cnt, output bit other_ack);
    bit done;
    done = 1'b0; cycles = 0; cs_cnt = 0; other_ack = 1'b0; rdata = 16'hxxxx; err = 1'bx;
    @(negedge clk);
    if (port == 1'b0) begin
      cpu0.req = 1'b1; cpu0.we = we; cpu0.addr = addr; cpu0.wdata = wdata;
    end else begin
      dma0.req = 1'b1; dma0.we = we; dma0.addr = addr; dma0.wdata = wdata;
    end
    while (!done && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (ram0_cs === 1'b1) cs_cnt++;
      if (port == 1'b0) begin
        if (dma0.ack !== 1'b0) other_ack = 1'b1;
        if (cpu0.ack === 1'b1) begin done = 1'b1; rdata = cpu0.rdata; err = cpu0.err; end
      end else begin
        if (cpu0.ack !== 1'b0) other_ack = 1'b1;
        if (dma0.ack === 1'b1) begin done = 1'b1; rdata = dma0.rdata; err = dma0.err; end
      end
    end
    cpu0.req = 1'b0;
    dma0.req = 1'b0;
    if (!done) cycles = -1;
  endtask

  initial begin
    logic [15:0] rd;
    logic        er;
    int          cyc, csn, acks, exp1;
    bit          oth;
    int          q0[$];
    int          q1[$];
    int          exp0[4];

    cpu0.req = 1'b0; cpu0.we = 1'b0; cpu0.addr = 16'h0; cpu0.wdata = 16'h0;
    dma0.req = 1'b0; dma0.we = 1'b0; dma0.addr = 16'h0; dma0.wdata = 16'h0;
    cpu1.req = 1'b0; cpu1.we = 1'b0; cpu1.addr = 16'h0; cpu1.wdata = 16'h0;
    dma1.req = 1'b0; dma1.we = 1'b0; dma1.addr = 16'h0; dma1.wdata = 16'h0;
    reset_n = 1'b0;
    mem[16'h3000] = 16'h1234;
    mem[16'h4000] = 16'h0000;
    repeat (3) @(negedge clk);
    check_reset0("rst");
    reset_n = 1'b1;

    // cpu read of preloaded word
    access0(1'b0, 1'b0, 16'h3000, 16'h0, 20, rd, er, cyc, csn, oth);
    check("rd3000_latency", 32'(cyc), 32'd3);
    check("rd3000_rdata",   32'(rd),  32'h1234);
    check("rd3000_err",     32'(er),  32'd0);
    check("rd3000_cs_cyc",  32'(csn), 32'd1);
    check("rd3000_dma_ack", 32'(oth), 32'd0);
    @(negedge clk);
    check("idle_busy", 32'(busy0), 32'd0);

    // dma write then cpu read-back
    access0(1'b1, 1'b1, 16'h4000, 16'hBEEF, 20, rd, er, cyc, csn, oth);
    check("wr4000_latency", 32'(cyc), 32'd3);
    check("wr4000_rdata",   32'(rd),  32'h0000);
    check("wr4000_err",     32'(er),  32'd0);
    check("wr4000_cpu_ack", 32'(oth), 32'd0);
    check("wr4000_mem",     32'(mem[16'h4000]), 32'hBEEF);
    access0(1'b0, 1'b0, 16'h4000, 16'h0, 20, rd, er, cyc, csn, oth);
    check("rd4000_rdata",   32'(rd),  32'hBEEF);
    check("rd4000_err",     32'(er),  32'd0);

    // Fresh reset so the first tie goes to cpu, then both ports held on both DUTs
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    cpu0.req = 1'b1; cpu0.we = 1'b0; cpu0.addr = 16'h3000;
    dma0.req = 1'b1; dma0.we = 1'b0; dma0.addr = 16'h4000;
    cpu1.req = 1'b1; cpu1.we = 1'b0; cpu1.addr = 16'h0111;
    dma1.req = 1'b1; dma1.we = 1'b0; dma1.addr = 16'h0222;
    for (int c = 0; c < 40 && (q0.size() < 4 || q1.size() < 4); c++) begin
      @(negedge clk);
      if (cpu0.ack === 1'b1) begin q0.push_back(0); check("rr_cpu_rdata", 32'(cpu0.rdata), 32'h1234); end
      if (dma0.ack === 1'b1) begin q0.push_back(1); check("rr_dma_rdata", 32'(dma0.rdata), 32'hBEEF); end
      if (cpu1.ack === 1'b1) begin q1.push_back(0); check("fp_cpu_rdata", 32'(cpu1.rdata), 32'h0111); end
      if (dma1.ack === 1'b1) q1.push_back(1);
      if (q0.size() >= 4) begin cpu0.req = 1'b0; dma0.req = 1'b0; end
      if (q1.size() >= 4) begin cpu1.req = 1'b0; dma1.req = 1'b0; end
    end
    cpu0.req = 1'b0; dma0.req = 1'b0; cpu1.req = 1'b0; dma1.req = 1'b0;
    check("rr_grant_count", 32'(q0.size()), 32'd4);
    check("fp_grant_count", 32'(q1.size()), 32'd4);
    exp0[0] = 0; exp0[1] = 1; exp0[2] = 0; exp0[3] = 1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr_grant%0d", i), 32'((i < q0.size()) ? q0[i] : 9), 32'(exp0[i]));
      exp1 = 0;
      check($sformatf("fp_grant%0d", i), 32'((i < q1.size()) ? q1[i] : 9), 32'(exp1));
    end

    // Timeout with ready stuck low: 2 cycles to WAIT, then 15 WAIT cycles
    @(negedge clk); stall = 1'b1;
    access0(1'b0, 1'b0, 16'h3000, 16'h0, 40, rd, er, cyc, csn, oth);
    check("tmo_latency", 32'(cyc), 32'd17);
    check("tmo_err",     32'(er),  32'd1);
    check("tmo_rdata",   32'(rd),  32'h0000);
    check("tmo_cs_cyc",  32'(csn), 32'd1);
    stall = 1'b0;
    access0(1'b0, 1'b0, 16'h4000, 16'h0, 20, rd, er, cyc, csn, oth);
    check("post_tmo_latency", 32'(cyc), 32'd3);
    check("post_tmo_rdata",   32'(rd),  32'hBEEF);
    check("post_tmo_err",     32'(er),  32'd0);

    // Reset in the middle of WAIT abandons the access
    @(negedge clk); stall = 1'b1;
    cpu0.req = 1'b1; cpu0.we = 1'b0; cpu0.addr = 16'h3000;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (cpu0.ack === 1'b1) acks++;
    end
    check("mid_busy_before", 32'(busy0), 32'd1);
    reset_n = 1'b0; cpu0.req = 1'b0;
    @(negedge clk);
    check_reset0("midrst");
    reset_n = 1'b1; stall = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (cpu0.ack === 1'b1) acks++;
    end
    check("midrst_no_ack", 32'(acks), 32'd0);
    access0(1'b0, 1'b0, 16'h3000, 16'h0, 20, rd, er, cyc, csn, oth);
    check("after_rst_latency", 32'(cyc), 32'd3);
    check("after_rst_rdata",   32'(rd),  32'h1234);
    check("after_rst_err",     32'(er),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3_mem_arbiter.md
Name: lc3_mem_arbiter

Overview:
Two-port arbiter and sequencer in front of lc3_ram. It shares the single RAM port between the CPU memory interface (port 0, "cpu") and a DMA/loader interface (port 1, "dma"). It owns the RAM cs/r_w strobes, waits for RAM ready with a timeout, and returns read data or error to the winning requester with a one-cycle ack.

Parameters:
- DATA_WIDTH, 16, word width of requesters and RAM.
- ADDR_WIDTH, 16, address width (matches RAM addr).
- FIXED_PRIORITY, 0, 0 = round-robin between ports; 1 = cpu always wins ties.
- WAIT_LIMIT, 15, maximum cycles spent in WAIT before an error response; range 1..255.

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- cpu_req  in  1  cpu access request; hold with fields stable until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_WIDTH  word address.
- cpu_wdata  in  DATA_WIDTH  write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_WIDTH  read data, valid only while cpu_ack=1.
- cpu_err  out  1  timeout flag, valid only while cpu_ack=1.
- dma_req, dma_we, dma_addr, dma_wdata, dma_ack, dma_rdata, dma_err: same as the cpu set, for port 1.
- ram_cs  out  1  to RAM cs.
- ram_r_w  out  1  to RAM r_w (1 = write).
- ram_addr  out  ADDR_WIDTH  to RAM addr.
- ram_data_in  out  DATA_WIDTH  to RAM data_in.
- ram_ready  in  1  from RAM ready.
- ram_data_out  in  DATA_WIDTH  from RAM data_out.
- busy  out  1  high in every state except IDLE.

Behaviour:
- All outputs are registered or decoded from registered state only. No combinational path from any req input to any ram_* output.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req=1 at the edge: pick the owner, latch that port's we/addr/wdata, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - ram_cs=1, ram_r_w=latched we, ram_addr/ram_data_in = latched values.
  - Lasts exactly one cycle, then WAIT.
  - The RAM commits a write at the ISSUE-ending edge.
- WAIT:
  - ram_cs=0.
  - wait_cnt clears on entry and increments each WAIT cycle.
  - If ram_ready=1: capture ram_data_out (reads only; writes capture 0), err=0, go to RESP.
  - Else if wait_cnt==WAIT_LIMIT-1: rdata=0, err=1, go to RESP.
- RESP:
  - Owner's ack=1 for exactly one cycle, with its rdata/err.
  - The other port's ack/rdata/err stay 0.
  - Always go to IDLE next.
- Latency: req sampled at edge E0, ack high in the cycle after E2 (3 cycles req-to-ack with a nominal RAM). Throughput is one access per 4 cycles.
- A req still high in the RESP cycle is sampled in IDLE as a new request, so a requester drops req in its ack cycle unless it issues another access.
- Arbitration:
  - Only one port requesting: that port wins.
  - Both requesting and FIXED_PRIORITY=1: cpu wins.
  - Both requesting and FIXED_PRIORITY=0: the port that was not last_owner wins. last_owner updates on every grant.
- Requests arriving while busy are not seen until IDLE; they are never dropped as long as req is held.
- Reset values (reset_n=0 at an edge, in any state):
  - state=IDLE, ram_cs=0, ram_r_w=0, ram_addr=0, ram_data_in=0.
  - all acks/errs=0, all rdata=0, busy=0, wait_cnt=0.
  - last_owner=dma, so cpu wins the first tie.
- Reset mid-operation: the access is abandoned and no ack is issued. A write whose ISSUE edge already occurred stays committed in RAM.
- Address/data pass through unmodified; no wrap or width arithmetic beyond wait_cnt, which is 8 bits and saturates by construction.

Decomposition:
- Package lc3_mem_pkg holds:
  - the state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3);
  - the port IDs (PORT_CPU=1'b0, PORT_DMA=1'b1);
  - default width constants LC3_DATA_WIDTH=16, LC3_ADDR_WIDTH=16.
- Sub-module lc3_rr_arbiter2 is purely combinational grant logic from (req[1:0], last_owner, FIXED_PRIORITY). The top level keeps the FSM, latches, counter and last_owner register.

Test Plan:
- Reset then cpu read of 0x3000 (preloaded 0x1234) -> ram_cs high exactly one cycle; cpu_ack one cycle, 3 cycles after req; cpu_rdata=0x1234, cpu_err=0; dma_ack stays 0.
- dma write 0xBEEF to 0x4000, then cpu read of 0x4000 -> dma_ack with dma_rdata=0; cpu later reads 0xBEEF.
- Both req held continuously for 4 accesses, FIXED_PRIORITY=0 -> grant order cpu, dma, cpu, dma. With FIXED_PRIORITY=1 -> cpu, cpu, cpu, cpu while cpu_req held.
- Stubbed RAM with ready tied 0, WAIT_LIMIT=15 -> ack after exactly 15 WAIT cycles with err=1, rdata=0; next access then succeeds normally.
- reset_n pulled low during WAIT of a cpu read -> no cpu_ack; all outputs at reset values the next cycle; the subsequent request completes correctly.
